clk_step_ctrl: RTL and testbench

- Debounced clock-source controller for the CPU/debug clock tree.
- Sequences three clock modes:
  - RUN: a tap of the free-running divider bus.
  - STEP: one pulse per button press.
  - BURST: N pulses per press.
- Replaces the raw mux of divider bit vs. manual pulse; output ck_out drives the downstream core clock enable/clock net.

---
 rtl/clk_ctrl_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 56 +++++
 rtl/clk_step_ctrl.sv | 162 ++++++++++++++++
 tb/tb_clk_step_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared encodings for the clock-step controller: mode codes, sequencer states
// and the mode-cycling helper.
package clk_ctrl_pkg;

    localparam logic [1:0] MODE_RUN   = 2'd0;
    localparam logic [1:0] MODE_STEP  = 2'd1;
    localparam logic [1:0] MODE_BURST = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic [1:0] next_mode(input logic [1:0] cur);
        case (cur)
            MODE_RUN:   next_mode = MODE_STEP;
            MODE_STEP:  next_mode = MODE_BURST;
            MODE_BURST: next_mode = MODE_RUN;
            default:    next_mode = MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-FF synchroniser, stability counter and a one-cycle
// press pulse on each accepted 0->1 level change.
module btn_debounce #(
    parameter int DEB_MAX = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic stable,
    output logic press
);

    localparam int CW = $clog2(DEB_MAX) + 1;

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synchronised level disagrees with the accepted one.
    always_comb begin
        stable_d = stable_q;
        press_d  = 1'b0;
        cnt_d    = {CW{1'b0}};
        if (sync2_q == stable_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CW'(DEB_MAX - 1)) begin
            stable_d = ~stable_q;
            press_d  = ~stable_q;
            cnt_d    = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1'b1);
        end
    end

    // Synchroniser and debounce state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= {CW{1'b0}};
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign press  = press_q;

endmodule

// File: rtl/clk_step_ctrl.sv
// Debounced clock-source controller: RUN (divider tap), STEP (one pulse) and
// BURST (N pulses). Define STEP_CNT_EN to enable the generated-pulse counter.
module clk_step_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DEB_MAX = 1000000,
    parameter int PULSE_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_step,
    input  logic             btn_mode,
    input  logic [7:0]       burst_n,
    input  logic [4:0]       tap_sel,
    input  logic [31:0]      div_bus,
    output logic             ck_out,
    output logic [1:0]       mode,
    output logic             busy,
    output logic [CNT_W-1:0] step_cnt
);

    localparam int              PH_W    = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PULSE_W - 1);
    localparam logic [PH_W-1:0] PH_ZERO = {PH_W{1'b0}};

    logic            step_press_s, mode_press_s;
    logic            unused_step_stable, unused_mode_stable;
    logic            mode_acc_s, step_acc_s;
    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [7:0]      rem_q, rem_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic            ck_q, ck_d;
    logic            busy_q, busy_d;

    btn_debounce #(.DEB_MAX(DEB_MAX)) u_deb_step (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_step),
        .stable  (unused_step_stable),
        .press   (step_press_s)
    );

    btn_debounce #(.DEB_MAX(DEB_MAX)) u_deb_mode (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_mode),
        .stable  (unused_mode_stable),
        .press   (mode_press_s)
    );

    // Presses only land in IDLE; a coincident mode press shadows the step press.
    assign mode_acc_s = (state_q == ST_IDLE) & mode_press_s;
    assign step_acc_s = (state_q == ST_IDLE) & step_press_s & ~mode_press_s &
                        (mode_q != MODE_RUN);

    // State, mode and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_RUN;
            rem_q   <= 8'd0;
            ph_q    <= PH_ZERO;
            ck_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            ph_q    <= ph_d;
            ck_q    <= ck_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: mode cycling and the HIGH/GAP pulse sequencer.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ph_d    = ph_q;
        if (mode_acc_s) begin
            mode_d = next_mode(mode_q);
        end else begin
            mode_d = mode_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (step_acc_s) begin
                    state_d = ST_HIGH;
                    ph_d    = PH_ZERO;
                    rem_d   = ((mode_q == MODE_BURST) && (burst_n != 8'd0)) ? burst_n : 8'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (ph_q == PH_LAST) begin
                    ph_d    = PH_ZERO;
                    rem_d   = rem_q - 8'd1;
                    state_d = (rem_q <= 8'd1) ? ST_IDLE : ST_GAP;
                end else begin
                    ph_d = ph_q + PH_W'(1'b1);
                end
            end
            ST_GAP: begin
                if (ph_q == PH_LAST) begin
                    ph_d    = PH_ZERO;
                    state_d = ST_HIGH;
                end else begin
                    ph_d = ph_q + PH_W'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = 8'd0;
                ph_d    = PH_ZERO;
            end
        endcase
    end

    // Outputs follow the next state so ck_out drops on the very edge mode leaves RUN.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        if (mode_d == MODE_RUN) begin
            ck_d = div_bus[tap_sel];
        end else begin
            ck_d = (state_d == ST_HIGH);
        end
    end

`ifdef STEP_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count every entry into HIGH; RUN mode never enters HIGH.
    always_comb begin
        if ((state_d == ST_HIGH) && (state_q != ST_HIGH)) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pulse counter register, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step_cnt = cnt_q;
`else
    assign step_cnt = {CNT_W{1'b0}};
`endif

    assign ck_out = ck_q;
    assign mode   = mode_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Scoreboard bench for clk_step_ctrl: directed stimulus pushes expected mode
// changes and pulse sequences; a negedge monitor pops and compares them.
module tb_clk_step_ctrl;

    localparam int DEB_MAX = 4;
    localparam int PULSE_W = 2;
    localparam int CNT_W   = 8;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             btn_step = 1'b0;
    logic             btn_mode = 1'b0;
    logic [7:0]       burst_n  = 8'd0;
    logic [4:0]       tap_sel  = 5'd3;
    logic [31:0]      div_bus  = 32'h7FFF_FFF0;
    logic             ck_out;
    logic [1:0]       mode;
    logic             busy;
    logic [CNT_W-1:0] step_cnt;

    typedef struct {
        int          len;
        int          highs;
        logic [31:0] pat;
        int          lat;
        int          cnt;
    } seq_t;

    seq_t       seq_q[$];
    logic [1:0] mode_q[$];

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   press_cyc  = 0;
    logic run_chk    = 1'b0;

    logic        prev_busy = 1'b0;
    logic [1:0]  prev_mode = 2'd0;
    logic        run_vld   = 1'b0;
    logic        run_exp   = 1'b0;
    int          m_len     = 0;
    int          m_highs   = 0;
    int          m_lat     = 0;
    logic [31:0] m_pat     = 32'd0;
    seq_t        m_e;

    clk_step_ctrl #(
        .DEB_MAX (DEB_MAX),
        .PULSE_W (PULSE_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_step (btn_step),
        .btn_mode (btn_mode),
        .burst_n  (burst_n),
        .tap_sel  (tap_sel),
        .div_bus  (div_bus),
        .ck_out   (ck_out),
        .mode     (mode),
        .busy     (busy),
        .step_cnt (step_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            div_bus = div_bus + 32'd1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int exp_cnt(input int v);
`ifdef STEP_CNT_EN
        return v % (1 << CNT_W);
`else
        return 0 * v;
`endif
    endfunction

    task automatic push_seq(input int len, input int highs, input logic [31:0] pat, input int cnt);
        seq_t e;
        e.len   = len;
        e.highs = highs;
        e.pat   = pat;
        e.lat   = 7;
        e.cnt   = exp_cnt(cnt);
        seq_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_step(input int hold);
        btn_step  = 1'b1;
        press_cyc = cyc;
        tick(hold);
        btn_step  = 1'b0;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        tick(8);
        btn_mode = 1'b0;
        tick(10);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            tick(1);
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    // Monitor: RUN tap tracking, mode changes and completed pulse sequences.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 1'b0;
                prev_mode = 2'd0;
                run_vld   = 1'b0;
                m_len     = 0;
            end else begin
                if (run_chk && run_vld) check("run_tap", ck_out, run_exp);
                run_exp = div_bus[tap_sel];
                run_vld = run_chk;
                if (mode !== prev_mode) begin
                    if (mode_q.size() == 0) begin
                        check("mode_unexpected", mode, prev_mode);
                    end else begin
                        check("mode_next", mode, mode_q.pop_front());
                        if (mode != 2'd0) check("ck_low_on_leave", ck_out, 1'b0);
                    end
                    prev_mode = mode;
                end
                if (busy && !prev_busy) begin
                    m_len   = 0;
                    m_highs = 0;
                    m_pat   = 32'd0;
                    m_lat   = cyc - press_cyc;
                end
                if (busy) begin
                    m_pat   = {m_pat[30:0], ck_out};
                    m_len   = m_len + 1;
                    m_highs = m_highs + int'(ck_out);
                end else if (prev_busy) begin
                    if (seq_q.size() == 0) begin
                        check("seq_unexpected", m_len, 0);
                    end else begin
                        m_e = seq_q.pop_front();
                        check("seq_len", m_len, m_e.len);
                        check("seq_highs", m_highs, m_e.highs);
                        check("seq_pattern", m_pat, m_e.pat);
                        check("seq_latency", m_lat, m_e.lat);
                        check("seq_step_cnt", step_cnt, m_e.cnt);
                    end
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        tick(3);
        check("rst_ck_out", ck_out, 1'b0);
        check("rst_mode", mode, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_step_cnt", step_cnt, 0);
        rst = 1'b0;

        // RUN: divider tap follows tap_sel, step presses ignored
        run_chk = 1'b1;
        tap_sel = 5'd3;
        tick(16);
        tap_sel = 5'd31;
        tick(8);
        tap_sel = 5'd0;
        press_step(8);
        tick(10);
        run_chk = 1'b0;
        check("run_no_busy", busy, 1'b0);

        // Mode press held, then a short bounce that must not count
        mode_q.push_back(2'd1);
        btn_mode = 1'b1;
        tick(10);
        btn_mode = 1'b0;
        tick(2);
        btn_mode = 1'b1;
        tick(2);
        btn_mode = 1'b0;
        tick(12);
        check("mode_is_step", mode, 2'd1);

        // Single step pulse
        push_seq(2, 2, 32'h3, 1);
        press_step(8);
        tick(10);
        wait_idle("step_idle");

        // Simultaneous presses: mode wins, no pulse
        mode_q.push_back(2'd2);
        btn_step = 1'b1;
        btn_mode = 1'b1;
        tick(8);
        btn_step = 1'b0;
        btn_mode = 1'b0;
        tick(10);
        check("mode_is_burst", mode, 2'd2);
        check("simul_no_busy", busy, 1'b0);

        // Burst of 3, burst_n changed after the press
        burst_n = 8'd3;
        push_seq(10, 6, 32'h333, 4);
        press_step(8);
        burst_n = 8'd255;
        tick(10);
        wait_idle("burst3_idle");

        // Burst of 4 with step and mode presses landing mid-burst
        burst_n = 8'd4;
        push_seq(14, 8, 32'h3333, 8);
        press_step(5);
        tick(6);
        btn_step = 1'b1;
        btn_mode = 1'b1;
        tick(8);
        btn_step = 1'b0;
        btn_mode = 1'b0;
        tick(10);
        wait_idle("burst4_idle");

        // burst_n of zero behaves as one
        burst_n = 8'd0;
        push_seq(2, 2, 32'h3, 9);
        press_step(8);
        tick(10);
        wait_idle("burst0_idle");

        // Reset during the second pulse of a burst
        burst_n = 8'd3;
        press_step(8);
        tick(3);
        check("pulse2_high", ck_out, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_ck_out", ck_out, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_mode", mode, 2'd0);
        check("abort_step_cnt", step_cnt, 0);
        tick(3);
        rst = 1'b0;
        tick(10);

        // Counter wrap: 255 pulses then one more
        mode_q.push_back(2'd1);
        press_mode();
        mode_q.push_back(2'd2);
        press_mode();
        burst_n = 8'd255;
        push_seq(1018, 510, 32'h3333_3333, 255);
        press_step(8);
        tick(10);
        wait_idle("burst255_idle");
        burst_n = 8'd0;
        push_seq(2, 2, 32'h3, 256);
        press_step(8);
        tick(10);
        wait_idle("wrap_idle");
        check("wrap_zero", step_cnt, 0);

        tick(4);
        check("seq_queue_empty", seq_q.size(), 0);
        check("mode_queue_empty", mode_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
